// File: rtl/mips32_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control path: state encoding,
// opcode/funct constants, mux encodings and the DECODE dispatch helper.
package mips32_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_R   = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_LW  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [2:0] OP_IMM_HI = 3'b001;
    localparam logic [5:0] FN_JR     = 6'b001000;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // S_FETCH as a result means the opcode is unsupported.
    function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_e nxt;
        if ((op == OP_RTYPE) && (fn == FN_JR)) begin
            nxt = S_JR;
        end else if (op == OP_RTYPE) begin
            nxt = S_EXEC_R;
        end else if (op[5:3] == OP_IMM_HI) begin
            nxt = S_EXEC_I;
        end else begin
            case (op)
                OP_LW, OP_SW:   nxt = S_ADDR;
                OP_BEQ, OP_BNE: nxt = S_BRANCH;
                OP_J:           nxt = S_JUMP;
                OP_JAL:         nxt = S_JAL;
                default:        nxt = S_FETCH;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl32_if.sv
// Shared instruction/data memory port: request/ready handshake plus access qualifiers.
interface multicycle_ctrl32_if;
    logic mem_req;
    logic mem_ready;
    logic MemWrite;
    logic IorD;

    modport master (output mem_req, output MemWrite, output IorD, input mem_ready);
    modport slave  (input mem_req, input MemWrite, input IorD, output mem_ready);
endinterface

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive cycles a memory request waits for ready; raises a sticky
// error once the wait reaches TMO cycles (TMO = 0 disables the error).
module mem_wait_watchdog #(
    parameter int TMO_W = 8,
    parameter int TMO   = 200
) (
    input  logic clock,
    input  logic resetn,
    input  logic waiting_i,
    output logic mem_err_o
);
    localparam logic [TMO_W-1:0] TMO_M1  = (TMO == 0) ? '0 : TMO_W'(TMO - 1);
    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next count and error: saturating count while waiting, flag set on the TMO-th wait cycle.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (waiting_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
            if ((TMO != 0) && (cnt_q >= TMO_M1)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err_o = err_q;
endmodule

// File: rtl/multicycle_ctrl32.sv
// Multi-cycle MIPS32 sequencer: steps each instruction through fetch/decode/execute/
// memory/write-back and drives the datapath controls from the current state.
module multicycle_ctrl32
    import mips32_pkg::*;
#(
    parameter int TMO_W = 8,
    parameter int TMO   = 200
) (
    input  logic                clock,
    input  logic                resetn,
    multicycle_ctrl32_if.master mem,
    input  logic [5:0]          Opcode,
    input  logic [5:0]          Function_opcode,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                nBranch,
    output logic [1:0]          PCSource,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                I_format,
    output logic                Sftmd,
    output logic                RegWrite,
    output logic                RegDST,
    output logic                MemtoReg,
    output logic                Jal,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                mem_err
);
    state_e state_q, state_d;
    state_e dec_next_s;
    logic   run_q;
    logic   is_sw_q, is_sw_d;
    logic   mem_req_s, mem_write_s, iord_s;

    // run_q holds everything quiet for the first cycle after reset release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            is_sw_q <= is_sw_d;
        end
    end

    // Instruction class seen in DECODE.
    always_comb begin
        dec_next_s = decode_next(Opcode, Function_opcode);
    end

    // Next-state logic; lw/sw choice is latched in DECODE since ADDR ignores the opcode.
    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        case (state_q)
            S_FETCH:  state_d = (run_q && mem.mem_ready) ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = dec_next_s;
                is_sw_d = (Opcode == OP_SW);
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_ADDR:   state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = mem.mem_ready ? S_WB_LW : S_MEM_RD;
            S_MEM_WR: state_d = mem.mem_ready ? S_FETCH : S_MEM_WR;
            S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; only fetch strobes and the store's done pulse look at mem_ready.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        iord_s      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        nBranch     = 1'b0;
        PCSource    = PCS_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUB_RT;
        ALUOp       = ALUOP_ADD;
        I_format    = 1'b0;
        Sftmd       = 1'b0;
        RegWrite    = 1'b0;
        RegDST      = 1'b0;
        MemtoReg    = 1'b0;
        Jal         = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = run_q;
                ALUSrcB   = run_q ? ALUB_FOUR : ALUB_RT;
                IRWrite   = run_q & mem.mem_ready;
                PCWrite   = run_q & mem.mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = ALUB_IMM_SH;
                illegal_op = (dec_next_s == S_FETCH);
                instr_done = (dec_next_s == S_FETCH);
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                Sftmd   = ~Function_opcode[5];
            end
            S_EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = ALUB_IMM;
                ALUOp    = ALUOP_FUNCT;
                I_format = 1'b1;
            end
            S_WB_R: begin
                RegWrite   = 1'b1;
                RegDST     = 1'b1;
                instr_done = 1'b1;
            end
            S_WB_I: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                instr_done  = mem.mem_ready;
            end
            S_WB_LW: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCS_ALUOUT;
                nBranch     = (Opcode == OP_BNE);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCS_JUMP;
                instr_done = 1'b1;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = PCS_JUMP;
                RegWrite   = 1'b1;
                Jal        = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = PCS_RS;
                instr_done = 1'b1;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    assign mem.mem_req  = mem_req_s;
    assign mem.MemWrite = mem_write_s;
    assign mem.IorD     = iord_s;

    mem_wait_watchdog #(
        .TMO_W (TMO_W),
        .TMO   (TMO)
    ) u_wdog (
        .clock     (clock),
        .resetn    (resetn),
        .waiting_i (mem_req_s & ~mem.mem_ready),
        .mem_err_o (mem_err)
    );
endmodule
